// File: rtl/uint16_display_controller_pkg.sv
// Shared types for the number-display blocks: digit codes, controller states
// and an elaboration-time power-of-ten helper.
package uint16_display_controller_pkg;

  typedef logic [3:0] Digit;
  localparam Digit EmptyDigit    = 4'hF;
  localparam int   UINT16_DIGITS = 5;

  typedef enum logic [1:0] {IDLE, CONVERT, FINISH} ctrl_state_t;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/uint16_display_controller_bcd_add3_step.sv
// Combinational double-dabble correction: every BCD nibble >= 5 gets +3
// ahead of the shift, so the nibble carries correctly into the next digit.
module bcd_add3_step
  import uint16_display_controller_pkg::*;
#(
  parameter int NUM_DIGITS = UINT16_DIGITS
) (
  input  Digit [NUM_DIGITS-1:0] bcd_i,
  output Digit [NUM_DIGITS-1:0] bcd_o
);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
    assign bcd_o[i] = (bcd_i[i] >= 4'd5) ? bcd_i[i] + 4'd3 : bcd_i[i];
  end

endmodule

// File: rtl/uint16_display_controller.sv
// Iterative binary-to-BCD front end for the 5-digit display, one bit per cycle.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module uint16_display_controller
  import uint16_display_controller_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_DIGITS = UINT16_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        value,
  input  logic                    in_valid,
  output logic                    in_ready,
  output Digit [NUM_DIGITS-1:0]   digits,
  output logic                    done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (pow10(NUM_DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_range_chk
    $error("NUM_DIGITS too small to hold the largest WIDTH-bit value");
  end

  ctrl_state_t           state_q, state_d;
  logic [WIDTH-1:0]      bin_sr_q, bin_sr_d;
  Digit [NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  Digit [NUM_DIGITS-1:0] digits_q, digits_d;
  logic                  done_q, done_d;

  Digit [NUM_DIGITS-1:0]            bcd_adj;
  Digit [NUM_DIGITS-1:0]            blanked;
  logic [4*NUM_DIGITS+WIDTH-1:0]    shifted;

  bcd_add3_step #(.NUM_DIGITS(NUM_DIGITS)) u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_adj)
  );

  assign shifted = {bcd_adj, bin_sr_q} << 1;

  always_comb begin
    blanked = bcd_q;
`ifdef LEADING_ZERO_BLANK_EN
    begin : blank_scan
      logic lead;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        if (lead && bcd_q[i] == 4'd0) blanked[i] = EmptyDigit;
        else                          lead       = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    bin_sr_d  = bin_sr_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    digits_d  = digits_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_sr_d  = value;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, bin_sr_d} = shifted;
        bit_cnt_d         = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        // Digits only move here, so the display never shows partial results.
        digits_d = blanked;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_sr_q  <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      digits_q  <= {NUM_DIGITS{EmptyDigit}};
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_sr_q  <= bin_sr_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      digits_q  <= digits_d;
      done_q    <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign digits   = digits_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uint16_display_controller.sv
// Scoreboard bench: stimulus pushes expected digits/done cycle, a negedge
// monitor checks digits, done and in_ready every cycle against the queue.
module tb_uint16_display_controller;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [15:0]     value = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [4:0][3:0] digits;
  logic            done;

  uint16_display_controller dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .digits   (digits),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] dig;
    int          acc;
    int          dn;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [19:0] cur = 20'hFFFFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Decimal digits straight from arithmetic, then optional leading-zero blanking.
  function automatic logic [19:0] model(input int v);
    int   d[5];
    logic [19:0] r;
    bit   lead;
    int   p;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      d[i] = (v / p) % 10;
      p = p * 10;
    end
    lead = 1'b1;
    for (int i = 4; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && i > 0 && d[i] == 0) r[i*4 +: 4] = 4'hF;
      else begin
        lead = 1'b0;
        r[i*4 +: 4] = 4'(d[i]);
      end
`else
      r[i*4 +: 4] = 4'(d[i]);
`endif
    end
    return r;
  endfunction

  // Any synchronous reset aborts in-flight work and blanks the display.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      cur = 20'hFFFFF;
    end
  end

  always @(negedge clk) begin
    bit busy;
    if (cyc > 0) begin
      busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].dn);
      chk("in_ready", 32'(in_ready), 32'(!busy));
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 32'(done), 32'd0);
        else begin
          chk("done_cycle", 32'(cyc), 32'(q[0].dn));
          cur = q[0].dig;
          void'(q.pop_front());
        end
      end
      chk("digits", 32'(digits), 32'(cur));
    end
  end

  // Present v and hold in_valid; returns the edge number at which it is accepted.
  task automatic send(input int v, input bit keep, output int acc);
    int n;
    exp_t e;
    @(negedge clk);
    value = 16'(v);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(n), 32'd0);
      acc = -1;
    end else begin
      acc = cyc + 1;
      e.dig = model(v);
      e.acc = acc;
      e.dn = acc + 17;
      q.push_back(e);
    end
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0;
      value = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int a1, a2, a3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // directed values, including boundaries
    send(65535, 0, a1);
    wait_idle();
    send(1234, 0, a1);
    wait_idle();
    send(0, 0, a1);
    wait_idle();
    send(10000, 0, a1);
    wait_idle();
    send(42, 0, a1);
    repeat (4) begin
      @(negedge clk);
      value = 16'($urandom);
    end
    wait_idle();

    // back-to-back with in_valid held; value disturbed while busy
    send(7, 1, a1);
    repeat (5) begin
      @(negedge clk);
      value = 16'd9999;
    end
    send(300, 0, a2);
    chk("b2b_spacing", 32'(a2 - a1), 32'd18);
    wait_idle();

    // reset in the middle of a conversion
    send(500, 0, a3);
    while (cyc < a3 + 7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_flushed", 32'(q.size()), 32'd0);
    send(5, 0, a3);
    wait_idle();

    // randomized traffic with random idle gaps
    for (int k = 0; k < 30; k++) begin
      send(int'($urandom_range(0, 65535)), 0, a1);
      if ($urandom_range(0, 1) == 1) wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uint16_display_controller.md
Name: uint16_display_controller

Overview:
- Sequential binary-to-decimal front end for the 5-digit UInt16 seven-segment display.
- Accepts a 16-bit unsigned value over a valid/ready handshake and converts it with iterative double-dabble (shift-add-3), one bit per cycle.
- Optionally blanks leading zeros, then presents five registered Digit codes. Each code feeds one existing per-digit segment decoder instance.
- Digit outputs change only on completion, so the display never shows intermediate values.

Parameters:
- WIDTH, 16, binary input width.
- NUM_DIGITS, 5, decimal digits produced. Requires 10^NUM_DIGITS > 2^WIDTH-1; elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  WIDTH  unsigned binary value to display; sampled only on accept.
- in_valid  input  1  requester has a value.
- in_ready  output  1  controller idle and able to accept.
- digits  output  NUM_DIGITS x Digit (4 bits each)  digits[0] = least significant; EmptyDigit = blank.
- done  output  1  one-cycle pulse in the cycle digits has just been updated.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; digits = all EmptyDigit; done=0; in_ready=1; shift/BCD registers cleared. rst has priority over everything, including mid-conversion. An aborted conversion never produces done and never updates digits.
- in_ready is combinational: high iff state==IDLE.
- Accept occurs at an edge where in_valid && in_ready:
  - bin_sr <= value; bcd <= 0; bit_cnt <= 0; state <= CONVERT.
- CONVERT, one edge per iteration:
  - Every BCD nibble >= 5 gets +3.
  - {bcd, bin_sr} then shifts left by 1.
  - bit_cnt increments. At bit_cnt==WIDTH-1, state <= FINISH.
- FINISH, one edge:
  - digits <= blanked bcd (see Optional Feature).
  - done <= 1; state <= IDLE.
- done is cleared at every other edge.
- Latency with accept at edge 0: CONVERT edges 1..WIDTH (1..16); FINISH edge 17. digits and done are valid after edge 17; in_ready is high after edge 17. Earliest next accept is edge 18, giving 18-cycle throughput when in_valid is held high.
- in_valid or value changes while busy are ignored and have no effect on the in-flight result.
- Input range: all values 0..65535 are legal; no overflow is possible (bcd width = 4*NUM_DIGITS).
- digits holds its last value indefinitely while IDLE.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: scan from digits[NUM_DIGITS-1] downward.
  - Each zero nibble becomes EmptyDigit until the first non-zero nibble.
  - digits[0] is never blanked, so value 0 displays "0".
- Undefined: all NUM_DIGITS nibbles are output verbatim, zeros included. The FINISH stage still exists, so latency is identical in both builds.

Decomposition:
- Shared types package gains:
  - Digit (4-bit), EmptyDigit (4'hF).
  - UINT16_DIGITS = 5.
  - ctrl_state_t enum {IDLE, CONVERT, FINISH}.
- Sub-module: bcd_add3_step, purely combinational.
  - Input: NUM_DIGITS BCD nibbles.
  - Output: nibbles after the conditional +3.
  - Reusable by other number-display blocks.
- The controller instantiates it once. It does not instantiate the segment decoders; the top level wires digits[i] to the per-digit decoder instances.

Test Plan:
- Reset value: assert rst 3 cycles -> digits all 4'hF, done=0, in_ready=1.
- value=65535 accepted at edge 0 -> after edge 17: digits[4..0]=6,5,5,3,5; done high exactly 1 cycle; in_ready low during edges 1..17.
- LEADING_ZERO_BLANK_EN defined, value=1234 -> digits[4..0]=F,1,2,3,4. value=0 -> F,F,F,F,0. value=10000 -> 1,0,0,0,0.
- LEADING_ZERO_BLANK_EN undefined, value=42 -> digits[4..0]=0,0,0,4,2; done at edge 17.
- Back-to-back with in_valid held high: value=7 then 300 -> second accept at edge 18, second done after edge 35. Changing value to 9999 during CONVERT does not alter the first result (7).
- Reset mid-op: accept 500, assert rst at edge 8 -> no done pulse; digits all F; in_ready=1 after that edge. A new accept of 5 completes normally 17 edges later.
